muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller for the MULT/MULTU/DIV/DIVU/MFHI/MFLO funct group, which the single-cycle
//  execute stage does not handle. Owns the HI/LO registers. Runs a 1-bit-per-cycle shift-add
//  multiply or restoring divide. Stalls the pipeline when a funct in its group arrives while busy.
//  Sits beside the execute stage, fed by the same rs/rt/func operands.
// PARAMETERS
//  DATA_WIDTH  32  operand, HI and LO width (W); the iteration count equals W
// PORTS
//  clock         in   1  rising-edge clock
//  reset_n       in   1  asynchronous, active-low reset
//  op_valid      in   1  an instruction with the funct on op_func is presented this cycle
//  op_func       in   6  funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO
//  rs            in   W  first operand (multiplicand / dividend)
//  rt            in   W  second operand (multiplier / divisor)
//  op_ready      out  1  high iff state==IDLE
//  stall         out  1  combinational: op_valid & func in group & ~op_ready
//  busy          out  1  high iff state!=IDLE (registered state decode)
//  result        out  W  registered MFHI/MFLO read data
//  result_valid  out  1  one-cycle pulse, result holds new data
//  div_by_zero   out  1  one-cycle pulse at completion of DIV/DIVU with rt==0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, HI=LO=0, result=0, result_valid=0, div_by_zero=0.
//   Any op in flight is aborted; nothing is written to HI/LO afterwards.
//  Accept: an instruction is accepted when op_valid & op_ready & func in group.
//   funct codes outside the group are ignored: no state change, stall=0.
//  FSM states: IDLE, RUN, FIX.
//   IDLE->RUN on an accepted MULT/MULTU/DIV/DIVU: latch op kind; clear the iteration counter;
//    latch operand magnitudes; for signed ops, latch the result sign bits.
//   RUN, W edges: one step per edge. Counter 0..W-1. Leave for FIX on the edge where counter==W-1.
//   FIX, 1 edge: apply sign correction, write HI/LO, pulse div_by_zero if set, ->IDLE.
//   MFHI/MFLO accepted in IDLE: state stays IDLE; next edge result<=HI (or LO), result_valid=1 for 1 cycle.
//  Latency: op accepted at edge t -> busy=1 for cycles t+1..t+W+1 (W+1 cycles).
//   HI/LO hold new values and op_ready=1 after edge t+W+1. An MFHI may be accepted that same cycle.
//  HI/LO are never partially updated; they change only in FIX, or at reset.
//  MULT/MULTU: {HI,LO} = full 2W-bit product. MULT is two's complement, negated in FIX if sign(rs)^sign(rt).
//  DIV/DIVU: LO = quotient, HI = remainder. Signed: quotient truncates toward zero.
//   Quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs).
//   Signed -2^(W-1) / -1: LO=0x80000000, HI=0 (wraps, no flag).
//  Divide by zero (rt==0, DIV or DIVU): still takes the full W+1 cycles. HI=rs, LO=all ones, div_by_zero pulses.
//  While busy, a group funct drives stall=1 and is not accepted. The requester must hold op_valid/op_func/rs/rt
//   until accepted. Operands are sampled only on the accept edge; changes during RUN have no effect.
//  op_valid with a group funct and reset_n low: not accepted.
// TESTING
//  1. MULT rs=0xFFFFFFFD (-3), rt=7 -> after W+1 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFLO -> result=0xFFFFFFEB, result_valid 1 cycle.
//  2. MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3. DIVU rs=0x12345678, rt=0 -> HI=0x12345678, LO=0xFFFFFFFF, div_by_zero pulses once at the FIX edge, busy drops after 33 cycles.
//  4. MULT accepted, then MFHI held with op_valid from the next cycle -> stall=1 and op_ready=0 for 33 cycles.
//     MFHI accepted in the first IDLE cycle returns the new HI; HI/LO never show an intermediate value.
//  5. Deassert reset_n 10 cycles into DIV rs=100, rt=7 -> busy=0, HI=LO=0 immediately. After release, MFLO returns 0 and no div_by_zero pulse.
//  6. Back-to-back DIV 100/7 then MULT 5*6 with op_valid held -> HI/LO=2/14 after the first op, then 0/30. ADD funct while busy -> stall=0.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between a requester and the
// multi-cycle multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int W = 32
);
  logic         op_valid;
  logic [5:0]   op_func;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         op_ready;
  logic         stall;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         div_by_zero;

  modport master (
    output op_valid, op_func, rs, rt,
    input  op_ready, stall, busy,
    input  result, result_valid, div_by_zero
  );

  modport slave (
    input  op_valid, op_func, rs, rt,
    output op_ready, stall, busy,
    output result, result_valid, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// HI/LO owner running 1-bit/cycle shift-add multiply
// and restoring divide for the MULT/DIV/MFHI/MFLO group.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic clock,
  input  logic reset_n,
  muldiv_sequencer_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic          r_is_div;
  logic          r_neg_lo;
  logic          r_neg_hi;
  logic          r_dz;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_result;
  logic          r_result_valid;
  logic          r_div_by_zero;

  logic          w_is_mul;
  logic          w_is_div;
  logic          w_signed;
  logic          w_is_mf;
  logic          w_mf_hi;
  logic          w_grp;
  logic          w_acc;
  logic          w_start;
  logic          w_mf;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [W-1:0]  w_a_abs;
  logic [W-1:0]  w_b_abs;
  logic [W:0]    w_sum;
  logic [W:0]    w_rem;
  logic [W:0]    w_diff;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_fx;
  logic [W-1:0]  w_quo_fx;
  logic [W-1:0]  w_rem_fx;

  // funct decode
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    w_is_mf  = 1'b0;
    w_mf_hi  = 1'b0;
    case (bus.op_func)
      F_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      F_MULTU: w_is_mul = 1'b1;
      F_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      F_DIVU:  w_is_div = 1'b1;
      F_MFHI:  begin w_is_mf = 1'b1; w_mf_hi = 1'b1; end
      F_MFLO:  w_is_mf = 1'b1;
      default: ;
    endcase
  end

  // accept qualification and operand magnitudes
  always_comb begin
    w_grp   = w_is_mul | w_is_div | w_is_mf;
    w_acc   = bus.op_valid & w_grp & (r_state == S_IDLE);
    w_start = w_acc & (w_is_mul | w_is_div);
    w_mf    = w_acc & w_is_mf;
    w_a_neg = w_signed & bus.rs[W-1];
    w_b_neg = w_signed & bus.rt[W-1];
    w_a_abs = w_a_neg ? -bus.rs : bus.rs;
    w_b_abs = w_b_neg ? -bus.rt : bus.rt;
  end

  // one iteration step and the final sign fix-up
  always_comb begin
    w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_rem     = {r_acc, r_q[W-1]};
    w_diff    = w_rem - {1'b0, r_b};
    w_prod    = {r_acc, r_q};
    w_prod_fx = r_neg_lo ? -w_prod : w_prod;
    w_quo_fx  = r_neg_lo ? -r_q : r_q;
    w_rem_fx  = r_neg_hi ? -r_acc : r_acc;
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_RUN;
      S_RUN:  if (r_cnt == CW'(W-1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // status outputs
  always_comb begin
    bus.op_ready     = (r_state == S_IDLE);
    bus.busy         = (r_state != S_IDLE);
    bus.stall        = bus.op_valid & w_grp & (r_state != S_IDLE);
    bus.result       = r_result;
    bus.result_valid = r_result_valid;
    bus.div_by_zero  = r_div_by_zero;
  end

  // datapath: latch, iterate, commit HI/LO, serve MFHI/MFLO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_is_div       <= 1'b0;
      r_neg_lo       <= 1'b0;
      r_neg_hi       <= 1'b0;
      r_dz           <= 1'b0;
      r_b            <= '0;
      r_acc          <= '0;
      r_q            <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_div_by_zero  <= 1'b0;
    end else begin
      r_result_valid <= w_mf;
      r_div_by_zero  <= (r_state == S_FIX) & r_dz;
      if (w_mf) r_result <= w_mf_hi ? r_hi : r_lo;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_cnt    <= '0;
          r_is_div <= w_is_div;
          r_neg_lo <= w_a_neg ^ w_b_neg;
          r_neg_hi <= w_a_neg;
          r_dz     <= w_is_div & (bus.rt == '0);
          r_b      <= w_b_abs;
          r_acc    <= '0;
          r_q      <= w_a_abs;
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_is_div) begin
            if (!w_diff[W]) begin
              r_acc <= w_diff[W-1:0];
              r_q   <= {r_q[W-2:0], 1'b1};
            end else begin
              r_acc <= w_rem[W-1:0];
              r_q   <= {r_q[W-2:0], 1'b0};
            end
          end else begin
            {r_acc, r_q} <= {w_sum, r_q[W-1:1]};
          end
        end
        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_fx;
          end else if (r_dz) begin
            r_hi <= w_rem_fx;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fx;
            r_lo <= w_quo_fx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
